// File: rtl/rx_bit_timer_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_pkg : bit-timing constants shared by the USB receive path blocks
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usb_rx_pkg;

  localparam int unsigned CLKS_PER_BIT  = 8;  // 96 MHz system clock / 12 Mbps
  localparam int unsigned SAMPLE_POINT  = 3;  // must be < CLKS_PER_BIT
  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned STUFF_LIMIT   = 6;

endpackage

`default_nettype wire

// File: rtl/rx_bit_timer_flex_counter.sv
// ---------------------------------------------------------------------------
// flex_counter : wrapping up-counter with synchronous clear and rollover flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flex_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ROLLOVER = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  localparam logic [WIDTH-1:0] ROLL_VAL = WIDTH'(ROLLOVER);

  // Clear wins over counting so a resync edge always restarts the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= (count == ROLL_VAL) ? '0 : count + 1'b1;
    end
  end

  assign rollover_flag = (count == ROLL_VAL);

endmodule

`default_nettype wire

// File: rtl/rx_bit_timer.sv
// ---------------------------------------------------------------------------
// rx_bit_timer : USB RX bit-timing recovery, mid-bit shift strobe, byte pulse.
// Optional bit unstuffing when RX_BIT_UNSTUFF_EN is defined.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_bit_timer
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable_timer,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_error
);

  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(BITS_PER_BYTE + 1);

  logic [CLK_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             unused_clk_wrap;
  logic             bit_full;
  logic             counted_shift;

  flex_counter #(
    .WIDTH    (CLK_W),
    .ROLLOVER (CLKS_PER_BIT - 1)
  ) u_clk_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (d_edge | ~enable_timer),
    .count_enable  (enable_timer),
    .count         (clk_cnt),
    .rollover_flag (unused_clk_wrap)
  );

  assign shift_enable = enable_timer & (clk_cnt == CLK_W'(SAMPLE_POINT)) & ~rst;

  // Holds BITS_PER_BYTE for one cycle, then its own rollover returns it to 0.
  flex_counter #(
    .WIDTH    (BIT_W),
    .ROLLOVER (BITS_PER_BYTE)
  ) u_bit_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (~enable_timer),
    .count_enable  (counted_shift | bit_full),
    .count         (bit_cnt),
    .rollover_flag (bit_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_received <= 1'b0;
    end else begin
      byte_received <= counted_shift & (bit_cnt == BIT_W'(BITS_PER_BYTE - 1));
    end
  end

`ifdef RX_BIT_UNSTUFF_EN
  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);

  logic [ONES_W-1:0] ones_cnt;
  logic              discard;

  // After STUFF_LIMIT ones the next strobe carries the stuffed bit.
  assign discard       = shift_enable & (ones_cnt == ONES_W'(STUFF_LIMIT));
  assign counted_shift = shift_enable & ~discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt    <= '0;
      stuff_error <= 1'b0;
    end else begin
      stuff_error <= discard & d_orig;
      if (!enable_timer || discard) begin
        ones_cnt <= '0;
      end else if (counted_shift) begin
        ones_cnt <= d_orig ? ones_cnt + 1'b1 : '0;
      end
    end
  end
`else
  logic unused_d_orig;

  assign unused_d_orig = d_orig;
  assign counted_shift = shift_enable;
  assign stuff_error   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_rx_bit_timer : scoreboard bench; expected strobe/pulse cycles are queued
// as stimulus is driven and popped by a negedge monitor.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_bit_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_timer = 1'b0;
  logic d_edge = 1'b0;
  logic d_orig = 1'b0;
  logic shift_enable;
  logic byte_received;
  logic stuff_error;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_se[$];
  int exp_br[$];
  int exp_err[$];

  rx_bit_timer dut (
    .clk           (clk),
    .rst           (rst),
    .enable_timer  (enable_timer),
    .d_edge        (d_edge),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .stuff_error   (stuff_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: each output pulse must match the head of its queue.
  always @(negedge clk) begin
    if (shift_enable) begin
      n_checks++;
      if (exp_se.size() == 0 || exp_se[0] != cyc) begin
        n_fail++;
        $display("FAIL shift_enable: pulse at cycle %0d, next expected %0d", cyc, (exp_se.size() != 0) ? exp_se[0] : -1);
      end
      if (exp_se.size() != 0 && exp_se[0] <= cyc) void'(exp_se.pop_front());
    end else if (exp_se.size() != 0 && exp_se[0] <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL shift_enable: got 0 at cycle %0d, expected pulse", cyc);
      void'(exp_se.pop_front());
    end

    if (byte_received) begin
      n_checks++;
      if (exp_br.size() == 0 || exp_br[0] != cyc) begin
        n_fail++;
        $display("FAIL byte_received: pulse at cycle %0d, next expected %0d", cyc, (exp_br.size() != 0) ? exp_br[0] : -1);
      end
      if (exp_br.size() != 0 && exp_br[0] <= cyc) void'(exp_br.pop_front());
    end else if (exp_br.size() != 0 && exp_br[0] <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_received: got 0 at cycle %0d, expected pulse", cyc);
      void'(exp_br.pop_front());
    end

    if (stuff_error) begin
      n_checks++;
      if (exp_err.size() == 0 || exp_err[0] != cyc) begin
        n_fail++;
        $display("FAIL stuff_error: pulse at cycle %0d, next expected %0d", cyc, (exp_err.size() != 0) ? exp_err[0] : -1);
      end
      if (exp_err.size() != 0 && exp_err[0] <= cyc) void'(exp_err.pop_front());
    end else if (exp_err.size() != 0 && exp_err[0] <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL stuff_error: got 0 at cycle %0d, expected pulse", cyc);
      void'(exp_err.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // d_edge during the returned cycle t, enable_timer from t+1.
  task automatic start_stream(output int t);
    d_edge = 1'b1;
    t = cyc;
    tick();
    d_edge = 1'b0;
    enable_timer = 1'b1;
  endtask

  task automatic stop_stream();
    enable_timer = 1'b0;
    d_orig = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    int t;
    enable_timer = 1'b1;
    repeat (3) tick();
    n_checks += 3;
    if (shift_enable !== 1'b0) begin n_fail++; $display("FAIL reset_shift_enable: got %b, expected 0", shift_enable); end
    if (byte_received !== 1'b0) begin n_fail++; $display("FAIL reset_byte_received: got %b, expected 0", byte_received); end
    if (stuff_error !== 1'b0) begin n_fail++; $display("FAIL reset_stuff_error: got %b, expected 0", stuff_error); end
    enable_timer = 1'b0;
    rst = 1'b0;
    tick();
    n_checks += 2;
    if (dut.clk_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_clk_cnt: got %0d, expected 0", dut.clk_cnt); end
    if (dut.bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d, expected 0", dut.bit_cnt); end

    // Reset lands in the very cycle a strobe would otherwise fire.
    start_stream(t);
    exp_se.push_back(t + 4);
    exp_se.push_back(t + 12);
    goto_cyc(t + 20);
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (shift_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_shift_enable: got %b, expected 0", shift_enable); end
    if (byte_received !== 1'b0) begin n_fail++; $display("FAIL midreset_byte_received: got %b, expected 0", byte_received); end
    if (stuff_error !== 1'b0) begin n_fail++; $display("FAIL midreset_stuff_error: got %b, expected 0", stuff_error); end
    if (dut.clk_cnt !== 3'd0) begin n_fail++; $display("FAIL midreset_clk_cnt: got %0d, expected 0", dut.clk_cnt); end
    if (dut.bit_cnt !== 4'd0) begin n_fail++; $display("FAIL midreset_bit_cnt: got %0d, expected 0", dut.bit_cnt); end
    enable_timer = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks += 3;
    if (dut.clk_cnt !== 3'd0) begin n_fail++; $display("FAIL release_clk_cnt: got %0d, expected 0", dut.clk_cnt); end
    if (dut.bit_cnt !== 4'd0) begin n_fail++; $display("FAIL release_bit_cnt: got %0d, expected 0", dut.bit_cnt); end
    if (exp_se.size() != 0) begin n_fail++; $display("FAIL reset_pending: %0d strobes outstanding, expected 0", exp_se.size()); end
  endtask

  task automatic test_single_byte();
    int t;
    start_stream(t);
    for (int k = 0; k < 8; k++) exp_se.push_back(t + 4 + 8 * k);
    exp_br.push_back(t + 61);
    goto_cyc(t + 64);
    stop_stream();
    n_checks++;
    if (exp_se.size() + exp_br.size() != 0) begin n_fail++; $display("FAIL single_byte_pending: %0d events outstanding, expected 0", exp_se.size() + exp_br.size()); end
  endtask

  task automatic test_resync();
    int t;
    start_stream(t);
    exp_se.push_back(t + 4);
    exp_se.push_back(t + 11);
    exp_se.push_back(t + 15);
    exp_se.push_back(t + 23);
    goto_cyc(t + 7);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    goto_cyc(t + 11);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    goto_cyc(t + 24);
    stop_stream();
    n_checks += 2;
    if (exp_se.size() != 0) begin n_fail++; $display("FAIL resync_pending: %0d strobes outstanding, expected 0", exp_se.size()); end
    if (dut.bit_cnt !== 4'd0) begin n_fail++; $display("FAIL resync_bit_cnt: got %0d, expected 0", dut.bit_cnt); end
  endtask

  task automatic test_abort();
    int t;
    int u;
    start_stream(t);
    for (int k = 0; k < 5; k++) exp_se.push_back(t + 4 + 8 * k);
    goto_cyc(t + 37);
    enable_timer = 1'b0;
    goto_cyc(t + 40);
    start_stream(u);
    for (int k = 0; k < 8; k++) exp_se.push_back(u + 4 + 8 * k);
    exp_br.push_back(u + 61);
    goto_cyc(u + 64);
    stop_stream();
    n_checks++;
    if (exp_se.size() + exp_br.size() != 0) begin n_fail++; $display("FAIL abort_pending: %0d events outstanding, expected 0", exp_se.size() + exp_br.size()); end
  endtask

  task automatic test_back_to_back();
    int t;
    start_stream(t);
    for (int k = 0; k < 24; k++) exp_se.push_back(t + 4 + 8 * k);
    for (int b = 0; b < 3; b++) exp_br.push_back(t + 61 + 64 * b);
    goto_cyc(t + 192);
    stop_stream();
    n_checks++;
    if (exp_se.size() + exp_br.size() != 0) begin n_fail++; $display("FAIL back_to_back_pending: %0d events outstanding, expected 0", exp_se.size() + exp_br.size()); end
  endtask

`ifdef RX_BIT_UNSTUFF_EN
  task automatic test_unstuff();
    int t;
    // Six ones, stuffed zero, two more bits: byte completes on the 9th strobe.
    d_orig = 1'b1;
    start_stream(t);
    for (int k = 0; k < 9; k++) exp_se.push_back(t + 4 + 8 * k);
    exp_br.push_back(t + 69);
    goto_cyc(t + 45);
    d_orig = 1'b0;
    goto_cyc(t + 72);
    stop_stream();
    // Seven ones: the stuffed position carries a 1.
    d_orig = 1'b1;
    start_stream(t);
    for (int k = 0; k < 7; k++) exp_se.push_back(t + 4 + 8 * k);
    exp_err.push_back(t + 53);
    goto_cyc(t + 54);
    stop_stream();
    n_checks++;
    if (exp_se.size() + exp_br.size() + exp_err.size() != 0) begin n_fail++; $display("FAIL unstuff_pending: %0d events outstanding, expected 0", exp_se.size() + exp_br.size() + exp_err.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_resync();
    test_abort();
    test_back_to_back();
`ifdef RX_BIT_UNSTUFF_EN
    test_unstuff();
`endif
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
